// File: rtl/pipe_skid_reg.sv
// Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// Every output comes straight from a flop, so upstream stalls never see downstream ready combinationally.
module pipe_skid_reg #(
    parameter int                DATA_W    = 160,
    parameter int                NOP_LSB   = 128,
    parameter int                NOP_W     = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}},
    parameter int                CNT_W     = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Clr,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Data,
    output logic [1:0]        Occupancy,
    output logic [CNT_W-1:0]  Stall_Cnt
);

    // Bit mask that selects the instruction field cleared on a flush.
    function automatic logic [DATA_W-1:0] nop_mask();
        logic [DATA_W-1:0] mask;
        for (int i = 0; i < DATA_W; i++) begin
            mask[i] = (i >= NOP_LSB) && (i < NOP_LSB + NOP_W);
        end
        return mask;
    endfunction

    localparam logic [DATA_W-1:0] NOP_MASK = nop_mask();
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    logic [DATA_W-1:0] m_data_r, m_data_s;
    logic [DATA_W-1:0] s_data_r, s_data_s;
    logic              mv_r, mv_s;
    logic              sv_r, sv_s;
    logic              in_ready_r;
    logic [1:0]        occ_r, occ_s;
    logic [CNT_W-1:0]  stall_cnt_r, stall_cnt_s;
    logic              in_fire_s, out_fire_s, m_free_s;

    // Next-state selection for the main/skid entries and the stall counter.
    always_comb begin
        in_fire_s   = In_Valid & ~sv_r;
        out_fire_s  = mv_r & Out_Ready;
        m_free_s    = ~mv_r | out_fire_s;
        m_data_s    = m_data_r;
        s_data_s    = s_data_r;
        mv_s        = mv_r;
        sv_s        = sv_r;
        stall_cnt_s = stall_cnt_r;

        if (Clr) begin
            // Bubble: keep the rest of the payload, zero the instruction so it decodes as NOP.
            mv_s     = 1'b0;
            sv_s     = 1'b0;
            m_data_s = m_data_r & ~NOP_MASK;
        end else if (m_free_s) begin
            if (sv_r) begin
                m_data_s = s_data_r;
                mv_s     = 1'b1;
                if (in_fire_s) begin
                    s_data_s = In_Data;
                    sv_s     = 1'b1;
                end else begin
                    sv_s     = 1'b0;
                end
            end else if (in_fire_s) begin
                m_data_s = In_Data;
                mv_s     = 1'b1;
                sv_s     = 1'b0;
            end else begin
                mv_s     = 1'b0;
                sv_s     = 1'b0;
            end
        end else begin
            if (in_fire_s) begin
                s_data_s = In_Data;
                sv_s     = 1'b1;
            end else begin
                sv_s     = sv_r;
            end
        end

        if (!Clr && mv_r && !Out_Ready && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_s = stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_s = stall_cnt_r;
        end

        occ_s = {1'b0, mv_s} + {1'b0, sv_s};
    end

    // State registers; In_Ready and Occupancy are precomputed so they leave the block as flops.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            m_data_r    <= RESET_VAL;
            s_data_r    <= {DATA_W{1'b0}};
            mv_r        <= 1'b0;
            sv_r        <= 1'b0;
            in_ready_r  <= 1'b1;
            occ_r       <= 2'd0;
            stall_cnt_r <= {CNT_W{1'b0}};
        end else begin
            m_data_r    <= m_data_s;
            s_data_r    <= s_data_s;
            mv_r        <= mv_s;
            sv_r        <= sv_s;
            in_ready_r  <= ~sv_s;
            occ_r       <= occ_s;
            stall_cnt_r <= stall_cnt_s;
        end
    end

    assign In_Ready  = in_ready_r;
    assign Out_Valid = mv_r;
    assign Out_Data  = m_data_r;
    assign Occupancy = occ_r;
    assign Stall_Cnt = stall_cnt_r;

endmodule
